// File: rtl/census_cost.sv
// Census matching cost: Hamming distance between each left code and the right codes at
// disparities 0..MAX_DISP-1. Optional winner-take-all output stage under CENSUS_COST_WTA_EN.
module census_cost #(
  parameter int MAX_DISP   = 16,
  parameter int CODE_WIDTH = 32,
  parameter int COST_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [CODE_WIDTH-1:0]          left_census,
  input  logic [CODE_WIDTH-1:0]          right_census,
  input  logic [9:0]                     row_in,
  input  logic [9:0]                     col_in,
  output logic [MAX_DISP*COST_WIDTH-1:0] cost_out,
  output logic [9:0]                     row_out,
  output logic [9:0]                     col_out,
  output logic                           valid
`ifdef CENSUS_COST_WTA_EN
  ,
  output logic [$clog2(MAX_DISP)-1:0]    best_disp,
  output logic [COST_WIDTH-1:0]          best_cost,
  output logic                           wta_valid
`endif
);

  localparam logic [COST_WIDTH-1:0] COST_MAX = '1;

  function automatic logic [COST_WIDTH-1:0] popcnt(input logic [CODE_WIDTH-1:0] v);
    logic [COST_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < CODE_WIDTH; i++) c = c + COST_WIDTH'(v[i]);
    return c;
  endfunction

  // rbuf[k] holds the right code accepted k+1 pixels ago; the oldest slot would
  // only feed a disparity of MAX_DISP, so it is not kept.
  logic [MAX_DISP-2:0][CODE_WIDTH-1:0] rbuf_q, rbuf_d;

  logic [MAX_DISP-1:0][CODE_WIDTH-1:0] x_q, x_d;
  logic [9:0]                          row_s1_q, row_s1_d, col_s1_q, col_s1_d;
  logic                                en_s1_q, en_s1_d;

  logic [MAX_DISP-1:0][COST_WIDTH-1:0] pc_q, pc_d;
  logic [MAX_DISP-1:0]                 mask_q, mask_d;
  logic [9:0]                          row_s2_q, row_s2_d, col_s2_q, col_s2_d;
  logic                                en_s2_q, en_s2_d;

  logic [MAX_DISP-1:0][COST_WIDTH-1:0] cost_q, cost_d;
  logic [9:0]                          row_q, row_d, col_q, col_d;
  logic                                valid_q, valid_d;

  always_comb begin
    rbuf_d = rbuf_q;
    if (en) begin
      rbuf_d[0] = right_census;
      for (int k = 1; k < MAX_DISP - 1; k++) rbuf_d[k] = rbuf_q[k-1];
    end

    x_d[0] = left_census ^ right_census;
    for (int d = 1; d < MAX_DISP; d++) x_d[d] = left_census ^ rbuf_q[d-1];
    row_s1_d = row_in;
    col_s1_d = col_in;
    en_s1_d  = en;

    // A disparity pointing left of column 0 would read the previous row's history.
    for (int d = 0; d < MAX_DISP; d++) begin
      pc_d[d]   = popcnt(x_q[d]);
      mask_d[d] = ({22'd0, col_s1_q} < 32'(d));
    end
    row_s2_d = row_s1_q;
    col_s2_d = col_s1_q;
    en_s2_d  = en_s1_q;

    for (int d = 0; d < MAX_DISP; d++) cost_d[d] = mask_q[d] ? COST_MAX : pc_q[d];
    row_d   = row_s2_q;
    col_d   = col_s2_q;
    valid_d = en_s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rbuf_q   <= '0;
      x_q      <= '0;
      row_s1_q <= '0;
      col_s1_q <= '0;
      en_s1_q  <= 1'b0;
      pc_q     <= '0;
      mask_q   <= '0;
      row_s2_q <= '0;
      col_s2_q <= '0;
      en_s2_q  <= 1'b0;
      cost_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      rbuf_q   <= rbuf_d;
      x_q      <= x_d;
      row_s1_q <= row_s1_d;
      col_s1_q <= col_s1_d;
      en_s1_q  <= en_s1_d;
      pc_q     <= pc_d;
      mask_q   <= mask_d;
      row_s2_q <= row_s2_d;
      col_s2_q <= col_s2_d;
      en_s2_q  <= en_s2_d;
      cost_q   <= cost_d;
      row_q    <= row_d;
      col_q    <= col_d;
      valid_q  <= valid_d;
    end
  end

  assign cost_out = cost_q;
  assign row_out  = row_q;
  assign col_out  = col_q;
  assign valid    = valid_q;

`ifdef CENSUS_COST_WTA_EN
  localparam int DW = $clog2(MAX_DISP);

  logic [DW-1:0]         best_disp_q, best_disp_d;
  logic [COST_WIDTH-1:0] best_cost_q, best_cost_d;
  logic                  wta_valid_q, wta_valid_d;

  // Strict less-than keeps the lowest disparity on ties.
  always_comb begin
    best_cost_d = cost_q[0];
    best_disp_d = '0;
    for (int d = 1; d < MAX_DISP; d++) begin
      if (cost_q[d] < best_cost_d) begin
        best_cost_d = cost_q[d];
        best_disp_d = DW'(d);
      end
    end
    wta_valid_d = valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_disp_q <= '0;
      best_cost_q <= '0;
      wta_valid_q <= 1'b0;
    end else begin
      best_disp_q <= best_disp_d;
      best_cost_q <= best_cost_d;
      wta_valid_q <= wta_valid_d;
    end
  end

  assign best_disp = best_disp_q;
  assign best_cost = best_cost_q;
  assign wta_valid = wta_valid_q;
`endif

endmodule

// File: tb/tb_census_cost.sv
// Scoreboard bench for census_cost: a software history model predicts each result at drive time.
module tb_census_cost;
  localparam int MD = 16;
  localparam int CW = 32;
  localparam int KW = 6;
  localparam int EW = 1 + 10 + 10 + MD*KW;  // {valid, row, col, costs}

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [CW-1:0]     left_census = '0;
  logic [CW-1:0]     right_census = '0;
  logic [9:0]        row_in = '0;
  logic [9:0]        col_in = '0;
  logic [MD*KW-1:0]  cost_out;
  logic [9:0]        row_out;
  logic [9:0]        col_out;
  logic              valid;
`ifdef CENSUS_COST_WTA_EN
  logic [3:0]        best_disp;
  logic [KW-1:0]     best_cost;
  logic              wta_valid;
  logic [EW-1:0]     wta_prev = '0;
`endif

  census_cost #(.MAX_DISP(MD), .CODE_WIDTH(CW), .COST_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .left_census(left_census), .right_census(right_census),
    .row_in(row_in), .col_in(col_in),
    .cost_out(cost_out), .row_out(row_out), .col_out(col_out), .valid(valid)
`ifdef CENSUS_COST_WTA_EN
    , .best_disp(best_disp), .best_cost(best_cost), .wta_valid(wta_valid)
`endif
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] hist[MD-1];
  logic          rst_prev = 1'b1;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    e = '0;
    if (exp_q.size() >= 3) e = exp_q.pop_front();
    if (rst_prev) begin
      check("reset_out", {valid, row_out, col_out, cost_out}, '0);
    end else if (e[EW-1]) begin
      check("valid", valid, 1'b1);
      check("row", row_out, e[EW-2 -: 10]);
      check("col", col_out, e[EW-12 -: 10]);
      check("cost", cost_out, e[MD*KW-1:0]);
    end else begin
      check("bubble", valid, 1'b0);
    end
`ifdef CENSUS_COST_WTA_EN
    if (rst_prev) begin
      check("wta_reset", {wta_valid, best_disp, best_cost}, '0);
    end else if (wta_prev[EW-1]) begin
      logic [KW-1:0] bc;
      logic [3:0]    bd;
      bc = wta_prev[KW-1:0];
      bd = '0;
      for (int d = 1; d < MD; d++)
        if (wta_prev[d*KW +: KW] < bc) begin bc = wta_prev[d*KW +: KW]; bd = 4'(d); end
      check("wta", {wta_valid, best_disp, best_cost}, {1'b1, bd, bc});
    end else begin
      check("wta_bubble", wta_valid, 1'b0);
    end
    wta_prev = rst_prev ? '0 : e;
`endif
  endtask

  task automatic drive(input logic r, input logic e, input logic [CW-1:0] l,
                       input logic [CW-1:0] rc, input logic [9:0] rw, input logic [9:0] cl);
    logic [EW-1:0]   x;
    logic [MD*KW-1:0] c;
    logic [CW-1:0]   rr;
    @(negedge clk);
    check_outputs();
    rst = r; en = e; left_census = l; right_census = rc; row_in = rw; col_in = cl;
    if (r) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        x = exp_q[i];
        x[EW-1] = 1'b0;
        exp_q[i] = x;
      end
      exp_q.push_back('0);
      for (int k = 0; k < MD-1; k++) hist[k] = '0;
    end else begin
      for (int d = 0; d < MD; d++) begin
        rr = (d == 0) ? rc : hist[d-1];
        c[d*KW +: KW] = (int'(cl) < d) ? KW'(63) : KW'($countones(l ^ rr));
      end
      exp_q.push_back({e, rw, cl, c});
      if (e) begin
        for (int k = MD-2; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = rc;
      end
    end
    rst_prev = r;
  endtask

  logic [CW-1:0] arr[64];
  logic [6:0]    bub;
  logic [9:0]    rcol;

  initial begin
    for (int k = 0; k < MD-1; k++) hist[k] = '0;

    // Reset held with en toggling, then idle.
    drive(1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 10'd3, 10'd9);
    drive(1, 0, 32'hFFFF_FFFF, 32'h0, 10'd3, 10'd10);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, '0, '0);

    // Identical codes on row 5.
    for (int c = 0; c <= 20; c++) drive(0, 1, 32'h0000_01FF, 32'h0000_01FF, 10'd5, 10'(c));

    // Known Hamming distance: right zero, left 8 ones.
    for (int c = 21; c <= 40; c++) drive(0, 1, 32'h0000_00FF, 32'h0, 10'd5, 10'(c));

    // Right image shifted by a disparity of 5.
    for (int i = 0; i < 64; i++) arr[i] = $urandom;
    for (int i = 0; i < 45; i++) drive(0, 1, arr[i], arr[i+5], 10'd6, 10'(20 + i));

    // Bubbles in the valid stream.
    bub = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    for (int i = 0; i < 7; i++) drive(0, bub[i], $urandom, $urandom, 10'd6, 10'(70 + i));
    for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, 10'd6, 10'd80);

    // Mid-frame reset at row 7 col 100, stream resumes at col 101.
    for (int c = 90; c < 100; c++) drive(0, 1, $urandom, $urandom, 10'd7, 10'(c));
    drive(1, 1, $urandom, $urandom, 10'd7, 10'd100);
    for (int c = 101; c <= 125; c++) drive(0, 1, $urandom, $urandom, 10'd7, 10'(c));

    // Random traffic with sparse columns and occasional resets.
    rcol = '0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) rcol = 10'($urandom_range(0, 20));
      else rcol = rcol + 10'($urandom_range(1, 3));
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
            10'($urandom_range(0, 1023)), rcol);
    end

    for (int i = 0; i < 5; i++) drive(0, 0, '0, '0, '0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
